// File: rtl/alu_seq_exec_if.sv
// Request/response bundle for alu_seq_exec: operation request in, result out,
// with valid/ready on both sides and a synchronous flush.
interface alu_seq_exec_if #(
    parameter int unsigned XLEN = 32
);
    logic [3:0]      control;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output control, op_a, op_b, in_valid, flush, out_ready,
        input  in_ready, result, zero, illegal, out_valid
    );

    modport slave (
        input  control, op_a, op_b, in_valid, flush, out_ready,
        output in_ready, result, zero, illegal, out_valid
    );
endinterface

// File: rtl/alu_seq_exec.sv
// Single-issue ALU: logic/arithmetic ops complete in one cycle, shifts iterate
// one bit per cycle. One request in flight; result held until consumed.
module alu_seq_exec #(
    parameter int unsigned XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_exec_if.slave bus
);
    localparam int unsigned SHW = $clog2(XLEN);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_PASS = 4'b1111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_d;
    logic [3:0]      ctl_q, ctl_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic            is_shift;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] acc_step;
    logic [XLEN-1:0] fin_res;

    assign shamt    = bus.op_b[SHW-1:0];
    assign is_shift = (bus.control == OP_SLL) || (bus.control == OP_SRL) ||
                      (bus.control == OP_SRA);

    // Single-cycle datapath for the non-shift codes
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (bus.control)
            OP_AND:  alu_res = bus.op_a & bus.op_b;
            OP_OR:   alu_res = bus.op_a | bus.op_b;
            OP_ADD:  alu_res = bus.op_a + bus.op_b;
            OP_SUB:  alu_res = bus.op_a - bus.op_b;
            OP_XOR:  alu_res = bus.op_a ^ bus.op_b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
            OP_PASS: alu_res = bus.op_b;
            OP_SLL, OP_SRL, OP_SRA: alu_res = bus.op_a;
            default: alu_ill = 1'b1;
        endcase
    end

    // One-bit shift step on the accumulator
    always_comb begin
        case (ctl_q)
            OP_SLL:  acc_step = {acc_q[XLEN-2:0], 1'b0};
            OP_SRL:  acc_step = {1'b0, acc_q[XLEN-1:1]};
            default: acc_step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
        endcase
    end

    // Next-state and datapath-update logic
    always_comb begin
        state_d   = state;
        ctl_d     = ctl_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        fin_res   = alu_res;
        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        ctl_d = bus.control;
                        if (is_shift && (shamt != '0)) begin
                            state_d   = SHIFT;
                            acc_d     = bus.op_a;
                            cnt_d     = shamt;
                            illegal_d = 1'b0;
                        end else begin
                            state_d   = DONE;
                            result_d  = fin_res;
                            zero_d    = (fin_res == '0);
                            illegal_d = alu_ill;
                        end
                    end
                end
                SHIFT: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_d  = DONE;
                        result_d = acc_step;
                        zero_d   = (acc_step == '0);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ctl_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_d;
            ctl_q     <= ctl_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed corner cases plus random
// requests compared against an arithmetic reference model.
module tb_alu_seq_exec;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    alu_seq_exec_if #(.XLEN(32)) bus();

    alu_seq_exec #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result, illegal flag and accept-to-out_valid latency
    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        r   = 32'd0;
        ill = 1'b0;
        lat = 1;
        case (c)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  r = a - b;
            4'd4:  begin r = a << sh; lat = 1 + sh; end
            4'd5:  begin r = a >> sh; lat = 1 + sh; end
            4'd6:  begin r = $unsigned($signed(a) >>> sh); lat = 1 + sh; end
            4'd7:  r = a ^ b;
            4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  r = (a < b) ? 32'd1 : 32'd0;
            4'd15: r = b;
            default: ill = 1'b1;
        endcase
    endfunction

    // Issue one request from IDLE and wait (bounded) for out_valid
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output logic ill, output int lat);
        bus.control  = c;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        r   = bus.result;
        z   = bus.zero;
        ill = bus.illegal;
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        logic z, ill;
        int lat;
        rst_n = 1'b0;
        bus.control = '0; bus.op_a = '0; bus.op_b = '0;
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        #2;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'd0 ||
            bus.zero !== 1'b0 || bus.illegal !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%b ov=%b res=%h z=%b ill=%b, want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.illegal);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_op(4'd2, 32'd5, 32'd7, r, z, ill, lat);
        n_vec++;
        if (lat !== 1 || r !== 32'd12) begin
            n_err++;
            $display("FAIL first_accept: lat=%0d res=%h, want 1 0000000c", lat, r);
        end
        retire();
    endtask

    task automatic test_vectors();
        logic [3:0]  tc[10] = '{4'd2, 4'd6, 4'd5, 4'd8, 4'd9, 4'd12, 4'd15, 4'd4, 4'd4, 4'd3};
        logic [31:0] ta[10] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h12345678, 32'h0, 32'hDEADBEEF, 32'h1, 32'h0};
        logic [31:0] tb[10] = '{32'h1, 32'h4, 32'h4, 32'h1, 32'h1, 32'h9, 32'h1234, 32'h20, 32'h1F, 32'h1};
        logic [31:0] tr[10] = '{32'h0, 32'hF8000000, 32'h08000000, 32'h1, 32'h0, 32'h0, 32'h1234,
                                32'hDEADBEEF, 32'h80000000, 32'hFFFFFFFF};
        logic        tz[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        ti[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int          tl[10] = '{1, 5, 5, 1, 1, 1, 1, 1, 32, 1};
        logic [31:0] r;
        logic z, ill;
        int lat;
        for (int i = 0; i < 10; i++) begin
            run_op(tc[i], ta[i], tb[i], r, z, ill, lat);
            n_vec++;
            if (r !== tr[i] || z !== tz[i] || ill !== ti[i] || lat !== tl[i]) begin
                n_err++;
                $display("FAIL directed_%0d: res=%h z=%b ill=%b lat=%0d, want %h %b %b %0d",
                         i, r, z, ill, lat, tr[i], tz[i], ti[i], tl[i]);
            end
            retire();
        end
    endtask

    task automatic test_random();
        logic [31:0] r, er, a, b;
        logic z, ill, eill;
        logic [3:0] c;
        int lat, elat, stall;
        for (int i = 0; i < 40; i++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
            model(c, a, b, er, eill, elat);
            run_op(c, a, b, r, z, ill, lat);
            n_vec++;
            if (r !== er || z !== (er == 32'd0) || ill !== eill || lat !== elat) begin
                n_err++;
                $display("FAIL random_%0d ctl=%h a=%h b=%h: res=%h z=%b ill=%b lat=%0d, want %h %b %b %0d",
                         i, c, a, b, r, z, ill, lat, er, (er == 32'd0), eill, elat);
            end
            stall = $urandom_range(0, 3);
            repeat (stall) @(posedge clk);
            #0;
            n_vec++;
            if (bus.result !== er || bus.out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL random_hold_%0d: res=%h ov=%b, want %h 1", i, bus.result, bus.out_valid, er);
            end
            retire();
            n_vec++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL random_retire_%0d: rdy=%b ov=%b, want 1 0", i, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        logic z, ill;
        int lat;
        run_op(4'd7, 32'hA5A5A5A5, 32'h0F0F0F0F, r, z, ill, lat);
        bus.control  = 4'd2;
        bus.op_a     = 32'h1;
        bus.op_b     = 32'h1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (bus.result !== 32'hAAAAAAAA || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL backpressure_%0d: res=%h rdy=%b ov=%b, want aaaaaaaa 0 1",
                         i, bus.result, bus.in_ready, bus.out_valid);
            end
        end
        bus.in_valid = 1'b0;
        retire();
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_release: rdy=%b ov=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
        repeat (2) @(posedge clk);
        #0;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_ignored: rdy=%b ov=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_flush();
        logic [31:0] r;
        logic z, ill;
        int lat, seen;
        bus.control = 4'd4; bus.op_a = 32'h1; bus.op_b = 32'd31; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_shift: rdy=%b ov=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL flush_no_result: out_valid cycles=%0d, want 0", seen);
        end
        run_op(4'd2, 32'd100, 32'd23, r, z, ill, lat);
        n_vec++;
        if (r !== 32'd123 || lat !== 1 || ill !== 1'b0) begin
            n_err++;
            $display("FAIL flush_followup: res=%h lat=%0d ill=%b, want 0000007b 1 0", r, lat, ill);
        end
        // flush wins over out_ready in DONE: state returns to IDLE either way, check no re-valid
        bus.flush = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_done: rdy=%b ov=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
        bus.control = 4'd2; bus.op_a = 32'd1; bus.op_b = 32'd1;
        bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_over_accept: rdy=%b ov=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        bus.control = 4'd6; bus.op_a = 32'h80000001; bus.op_b = 32'd20; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'd0 ||
            bus.zero !== 1'b0 || bus.illegal !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: rdy=%b ov=%b res=%h z=%b ill=%b, want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.illegal);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1 || bus.in_ready !== 1'b1) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL reset_no_stale: bad cycles=%0d, want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, er, a, b;
        logic z, ill, eill;
        logic [3:0] c;
        int lat, elat;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL out_ready_idle: rdy=%b ov=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
        for (int i = 0; i < 12; i++) begin
            c = (i % 3 == 0) ? 4'($urandom_range(4, 6)) : 4'($urandom_range(0, 9));
            a = $urandom;
            b = $urandom;
            model(c, a, b, er, eill, elat);
            run_op(c, a, b, r, z, ill, lat);
            n_vec++;
            if (r !== er || ill !== eill || lat !== elat) begin
                n_err++;
                $display("FAIL b2b_%0d ctl=%h: res=%h ill=%b lat=%0d, want %h %b %0d",
                         i, c, r, ill, lat, er, eill, elat);
            end
            @(posedge clk); #1;
            n_vec++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_idle_%0d: rdy=%b ov=%b, want 1 0", i, bus.in_ready, bus.out_valid);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_flush();
        test_reset_mid_shift();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_seq_exec.md
ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; shifts use b[4:0] for XLEN=32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 control  input  4  ALU operation code: 0000 and, 0001 or, 0010 add, 0011 sub, 0100 sll, 0101 srl, 0110 sra, 0111 xor, 1000 slt, 1001 sltu, 1010-1110 reserved, 1111 pass b.
REQ-005 op_a  input  XLEN  first operand.
REQ-006 op_b  input  XLEN  second operand / shift amount source.
REQ-007 in_valid  input  1  request present on control/op_a/op_b.
REQ-008 in_ready  output  1  block can accept a request.
REQ-009 flush  input  1  synchronous abort of any in-flight operation.
REQ-010 result  output  XLEN  operation result, valid while out_valid.
REQ-011 zero  output  1  result == 0, valid while out_valid.
REQ-012 illegal  output  1  request used a reserved code, valid while out_valid.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer accepts result.

Function
REQ-015 The block SHALL implement states IDLE, SHIFT, DONE; exactly one request in flight.
REQ-016 in_ready SHALL equal (state == IDLE); out_valid SHALL equal (state == DONE).
REQ-017 Accept SHALL occur on a rising edge with in_valid && in_ready && !flush; control and operands SHALL be captured at accept.
REQ-018 Non-shift codes SHALL compute in the accept cycle, register result, go IDLE->DONE; out_valid at accept+1.
REQ-019 add/sub SHALL wrap modulo 2^XLEN; slt signed compare, sltu unsigned, result 1 or 0 zero-extended.
REQ-020 Code 1111 SHALL return op_b; reserved codes SHALL return 0 with illegal=1; illegal=0 otherwise.
REQ-021 Shift codes with shamt = op_b[4:0] == 0 SHALL go IDLE->DONE with result = op_a, out_valid at accept+1.
REQ-022 Shift codes with shamt > 0 SHALL go IDLE->SHIFT, load accumulator = op_a, counter = shamt.
REQ-023 In SHIFT each cycle SHALL shift accumulator one bit (sll: zero in at LSB; srl: zero in at MSB; sra: replicate MSB) and decrement counter; when counter is 1 the next state SHALL be DONE.
REQ-024 Shift latency SHALL be accept-to-out_valid = 1 + shamt cycles (max 32 for shamt=31).
REQ-025 In DONE, result/zero/illegal SHALL hold stable until out_valid && out_ready, then state SHALL go IDLE; in_ready rises the following cycle.
REQ-026 Request inputs SHALL be ignored while in_ready = 0.
REQ-027 flush SHALL force state to IDLE on the next edge from any state, dropping any pending result; flush has priority over accept and over out_ready.
REQ-028 out_ready while not in DONE SHALL have no effect.

Reset
REQ-029 On rst_n low, asynchronously: state IDLE, in_ready 1, out_valid 0, result 0, zero 0, illegal 0, counter 0, accumulator 0.
REQ-030 Reset deasserted mid-operation state SHALL be lost; no result emitted for a request interrupted by reset.
REQ-031 First accept SHALL be possible on the first rising edge after rst_n rises.

Verification
REQ-032 add: op_a=0xFFFFFFFF, op_b=1, control=0010 -> out_valid at accept+1, result=0, zero=1, illegal=0.
REQ-033 sra: op_a=0x80000000, op_b=4, control=0110 -> in_ready 0 for 5 cycles, out_valid at accept+5, result=0xF8000000; srl same operands -> 0x08000000.
REQ-034 slt/sltu: op_a=0xFFFFFFFF, op_b=1 -> slt result 1, sltu result 0; code 1100 -> result 0, illegal=1; code 1111, op_b=0x1234 -> 0x1234.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable, in_ready 0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-036 flush asserted at accept+3 of sll shamt=31 -> IDLE next edge, no out_valid; following add request completes normally.
REQ-037 rst_n pulsed low during SHIFT -> outputs reset immediately without clock edge; no stale out_valid after release.
